// File: rtl/bin_gray.sv
// bin_gray: registered, width-parameterised binary <-> Gray code converter.
//
// Converts one code word per clock. dir selects the direction for each
// sample independently: dir=0 turns a binary word into Gray, dir=1 turns a
// Gray word back into binary. The result appears on gry one cycle after the
// sample, and out_valid is high for that one cycle. Both outputs come
// straight from flops.
//
// Handshake: a sample is taken on every rising clk edge where in_valid=1.
// There is no ready/backpressure. out_valid is high for exactly one cycle
// per accepted sample, and the consumer must take every such pulse. While
// in_valid=0, gry holds its last value and out_valid drops on the next edge.
//
// Optional feature (macro BIN_GRAY_STEP_CHK_EN): adds the output step_err.
// The block remembers the last Gray word produced with dir=0. step_err is
// raised with a new dir=0 result when that result differs from the
// remembered word in more than one bit. dir=1 results never flag and never
// update the remembered word. The first dir=0 result after reset never
// flags.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   sample bn/dir on this edge
//   dir       in   0 = binary-to-Gray, 1 = Gray-to-binary
//   bn        in   [WIDTH-1:0] input code word
//   out_valid out  gry holds a new result this cycle
//   gry       out  [WIDTH-1:0] converted code word
//   step_err  out  (BIN_GRAY_STEP_CHK_EN only) Gray step larger than one bit
module bin_gray #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             dir,
  input  logic [WIDTH-1:0] bn,
  output logic             out_valid,
  output logic [WIDTH-1:0] gry
`ifdef BIN_GRAY_STEP_CHK_EN
  ,
  output logic             step_err
`endif
);

  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] g2b;
  logic [WIDTH-1:0] conv;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  assign b2g = bn ^ (bn >> 1);

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  // Each bit is written as its own reduction, so there is no chained feedback
  // through the g2b vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign g2b[i] = ^bn[WIDTH-1:i];
  end

  assign conv = dir ? g2b : b2g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gry       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gry <= conv;
      end
    end
  end

`ifdef BIN_GRAY_STEP_CHK_EN
  logic [WIDTH-1:0] hist_q;
  logic             hist_vld_q;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  assign diff = b2g ^ hist_q;
  // More than one bit set: clearing the lowest set bit still leaves a bit.
  assign multi_bit = (diff & (diff - {{(WIDTH-1){1'b0}}, 1'b1})) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      // step_err lives only in the cycle of the result it describes.
      step_err <= 1'b0;
      if (in_valid && !dir) begin
        step_err   <= hist_vld_q && multi_bit;
        hist_q     <= b2g;
        hist_vld_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bin_gray.sv
// Testbench for bin_gray (WIDTH=4): directed vectors with hand-computed
// expected values. Inputs change on the falling edge; outputs are sampled
// 1 time unit after the rising edge.
module tb_bin_gray;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         dir;
  logic [W-1:0] bn;
  logic         out_valid;
  logic [W-1:0] gry;
`ifdef BIN_GRAY_STEP_CHK_EN
  logic         step_err;
`endif

  int n_checks;
  int n_fail;

  bin_gray #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .dir       (dir),
    .bn        (bn),
    .out_valid (out_valid),
    .gry       (gry)
`ifdef BIN_GRAY_STEP_CHK_EN
    ,
    .step_err  (step_err)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Binary 0..15 -> Gray, worked out by hand.
  logic [W-1:0] sweep_exp [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  // Driver: present one sample on the falling edge, then step to just after
  // the next rising edge so the registered result can be observed.
  task automatic drive(input logic v, input logic d, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = v;
    dir      = d;
    bn       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dir      = 1'b0;
    bn       = '0;
    #1;
    n_checks++;
    if (gry !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: gry=%b out_valid=%b, expected 0000/0", gry, out_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Load a non-zero value so the asynchronous clear is visible.
    drive(1'b1, 1'b0, 4'b0101);
    drive(1'b0, 1'b0, 4'b0000);
    // Mid-cycle, away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gry !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: gry=%b out_valid=%b, expected 0000/0", gry, out_valid);
    end
`ifdef BIN_GRAY_STEP_CHK_EN
    n_checks++;
    if (step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_step_err: step_err=%b, expected 0", step_err);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'b0101);
    n_checks++;
    if (gry !== 4'b0111 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_result: gry=%b out_valid=%b, expected 0111/1", gry, out_valid);
    end
    drive(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_sweep;
    for (int v = 0; v < 16; v++) begin
      drive(1'b1, 1'b0, 4'(v));
      n_checks++;
      if (gry !== sweep_exp[v] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep[%0d]: gry=%b out_valid=%b, expected %b/1", v, gry, out_valid, sweep_exp[v]);
      end
    end
    drive(1'b0, 1'b0, 4'b0000);
    n_checks++;
    if (out_valid !== 1'b0 || gry !== 4'b1000) begin
      n_fail++;
      $display("FAIL sweep_end_idle: gry=%b out_valid=%b, expected 1000/0", gry, out_valid);
    end
  endtask

  task automatic test_reverse;
    logic [W-1:0] in_tab  [4] = '{4'b1100, 4'b1000, 4'b0010, 4'b0000};
    logic [W-1:0] exp_tab [4] = '{4'b1000, 4'b1111, 4'b0011, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, in_tab[i]);
      n_checks++;
      if (gry !== exp_tab[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reverse[%b]: gry=%b out_valid=%b, expected %b/1", in_tab[i], gry, out_valid, exp_tab[i]);
      end
    end
    drive(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_round_trip;
    logic [W-1:0] g;
    for (int v = 0; v < 16; v++) begin
      drive(1'b1, 1'b0, 4'(v));
      g = gry;
      drive(1'b1, 1'b1, g);
      n_checks++;
      if (gry !== 4'(v) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL round_trip[%0d]: gry=%b out_valid=%b, expected %b/1", v, gry, out_valid, 4'(v));
      end
    end
    drive(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_back_to_back;
    logic         d_tab   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] in_tab  [4] = '{4'b0110, 4'b0110, 4'b1011, 4'b1011};
    logic [W-1:0] exp_tab [4] = '{4'b0101, 4'b0100, 4'b1110, 4'b1101};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d_tab[i], in_tab[i]);
      n_checks++;
      if (gry !== exp_tab[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL alt_dir[%0d]: gry=%b out_valid=%b, expected %b/1", i, gry, out_valid, exp_tab[i]);
      end
    end
    drive(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_gaps;
    drive(1'b1, 1'b0, 4'b1001);
    n_checks++;
    if (gry !== 4'b1101 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_pulse1: gry=%b out_valid=%b, expected 1101/1", gry, out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      // Input changes while idle must not disturb the held result.
      drive(1'b0, 1'b1, 4'b0110);
      n_checks++;
      if (gry !== 4'b1101 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_hold[%0d]: gry=%b out_valid=%b, expected 1101/0", i, gry, out_valid);
      end
    end
    drive(1'b1, 1'b0, 4'b0100);
    n_checks++;
    if (gry !== 4'b0110 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_pulse2: gry=%b out_valid=%b, expected 0110/1", gry, out_valid);
    end
    drive(1'b0, 1'b0, 4'b0000);
    n_checks++;
    if (gry !== 4'b0110 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_after2: gry=%b out_valid=%b, expected 0110/0", gry, out_valid);
    end
  endtask

  task automatic test_reset_in_flight;
    @(negedge clk);
    in_valid = 1'b1;
    dir      = 1'b0;
    bn       = 4'b0111;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gry !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_flight: gry=%b out_valid=%b, expected 0000/0", gry, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: out_valid=%b, expected 0", out_valid);
    end
    drive(1'b1, 1'b0, 4'b0011);
    n_checks++;
    if (gry !== 4'b0010 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_resume: gry=%b out_valid=%b, expected 0010/1", gry, out_valid);
    end
    drive(1'b0, 1'b0, 4'b0000);
  endtask

`ifdef BIN_GRAY_STEP_CHK_EN
  task automatic test_step_chk;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 17; v++) begin
      drive(1'b1, 1'b0, 4'(v % 16));
      n_checks++;
      if (step_err !== 1'b0) begin
        n_fail++;
        $display("FAIL step_sweep[%0d]: step_err=%b, expected 0", v, step_err);
      end
    end
    // A dir=1 sample in between neither flags nor updates the history.
    drive(1'b1, 1'b1, 4'b1111);
    n_checks++;
    if (step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL step_dir1: step_err=%b, expected 0", step_err);
    end
    drive(1'b1, 1'b0, 4'b0011);
    n_checks++;
    if (step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL step_one_bit: step_err=%b, expected 0", step_err);
    end
    drive(1'b1, 1'b0, 4'b0101);
    n_checks++;
    if (step_err !== 1'b1) begin
      n_fail++;
      $display("FAIL step_two_bit: step_err=%b, expected 1", step_err);
    end
    drive(1'b0, 1'b0, 4'b0000);
    n_checks++;
    if (step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL step_idle: step_err=%b, expected 0", step_err);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sweep();
    test_reverse();
    test_round_trip();
    test_back_to_back();
    test_gaps();
    test_reset_in_flight();
`ifdef BIN_GRAY_STEP_CHK_EN
    test_step_chk();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_gray.md
Name: bin_gray

Overview:
- Registered, width-parameterised binary-to-Gray code converter.
- Has a run-time selectable reverse direction (Gray-to-binary).
- Used wherever counters or pointers cross into Gray encoding, e.g. FIFO pointers and encoder interfaces.
- One clock domain; one-cycle latency; valid-qualified output.

Parameters:
- WIDTH, 4, bit width of input and output code words (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  bn is sampled on a clk edge when high
- dir  input  1  0 = binary-to-Gray, 1 = Gray-to-binary; sampled with bn
- bn  input  WIDTH  input code word (binary when dir=0, Gray when dir=1)
- out_valid  output  1  gry holds a new result for this cycle
- gry  output  WIDTH  converted code word (Gray when dir=0, binary when dir=1)

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-safe deassert by design of the registers):
  - gry = 0 and out_valid = 0 immediately.
  - All internal state cleared.
- dir=0 (binary-to-Gray):
  - gry[WIDTH-1] = bn[WIDTH-1].
  - gry[i] = bn[i+1] XOR bn[i] for i < WIDTH-1.
- dir=1 (Gray-to-binary):
  - gry[WIDTH-1] = bn[WIDTH-1].
  - gry[i] = gry[i+1] XOR bn[i], i.e. prefix XOR from the MSB down.
  - Purely combinational inside the cycle; no iteration across clocks.
- Latency:
  - Result registered on the clk edge where in_valid=1.
  - out_valid = 1 for exactly the following cycle per accepted input.
  - Back-to-back in_valid gives one result per cycle; throughput 1/cycle.
- in_valid=0:
  - gry holds its last value.
  - out_valid deasserts on the next edge.
- dir is per-sample; changing it between consecutive valid inputs is legal and takes effect for that sample only.
- No backpressure; the consumer must accept every out_valid pulse.
- Reset mid-stream: the in-flight result is discarded. The first in_valid after rst_n rises produces a normal result one cycle later.
- Boundaries (WIDTH=4):
  - All-zeros maps to all-zeros in both directions.
  - Binary 1111 maps to Gray 1000; Gray 1000 maps to binary 1111.
  - The 15 to 0 wrap differs in a single bit (1000 to 0000).
- Pure combinational paths from inputs to outputs are not permitted; both outputs come from flops.

Optional Feature:
- Macro: BIN_GRAY_STEP_CHK_EN
- Defined:
  - Adds output step_err (1 bit, reset 0).
  - The block stores the last Gray word produced with dir=0.
  - On each new dir=0 result, step_err = 1 for the out_valid cycle if the Hamming distance from the stored word is greater than 1; otherwise 0.
  - The first dir=0 result after reset never flags.
  - dir=1 results neither flag nor update the stored word.
  - Identical consecutive words (distance 0) do not flag.
- Undefined: port step_err absent, no history register, no other behavioural difference.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle -> gry=0000, out_valid=0 without waiting for a clk edge. Release, then bn=0101 dir=0 valid -> gry=0111, out_valid=1 next cycle.
- Full sweep, dir=0: bn=0000..1111, one per cycle -> gry = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, each one cycle after input, out_valid continuous.
- Reverse, dir=1: bn=1100 -> gry=1000; bn=1000 -> gry=1111; bn=0010 -> gry=0011; bn=0000 -> gry=0000.
- Round trip: for every 4-bit value v, convert with dir=0, feed the result back with dir=1 -> the original v returns. Alternating dir each cycle gives correct per-sample results.
- Gaps and hold: in_valid pulses with idle cycles between -> out_valid single-cycle pulses; gry holds its value during idle. A reset asserted in the cycle after in_valid -> no out_valid pulse.
- BIN_GRAY_STEP_CHK_EN:
  - Sweep 0..15 then wrap to 0 -> step_err stays 0.
  - Binary 0011 then 0101 (Gray 0010 then 0111) -> step_err=1 on the second result.
